// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and buffers
// one returned instruction for decode; also computes jump/branch redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redir_jump,
    input  logic        redir_branch,
    input  logic [31:0] redir_pc4,
    input  logic [25:0] redir_adr,
    input  logic [15:0] redir_imm
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        drop;
    logic        redir;
    logic [31:0] redir_target;
    logic        req_fire;
    logic        load;

    assign redir = redir_jump | redir_branch;

    // Jump wins over branch when both are asserted.
    always_comb begin
        if (redir_jump) begin
            redir_target = {redir_pc4[31:28], redir_adr, 2'b00};
        end else begin
            redir_target = redir_pc4 + {{14{redir_imm[15]}}, redir_imm, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ:  if (req_fire) state_next = S_WAIT;
            S_WAIT: if (imem_resp_valid) state_next = S_REQ;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && state == S_REQ && !redir && (!if_valid || if_ready)) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_addr = pc;
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign load      = (state == S_WAIT) && imem_resp_valid && !drop && !redir;

    // A redirect flushes the output register even if decode consumes it this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            drop           <= 1'b0;
            if_valid       <= 1'b0;
            if_instruction <= 32'h0;
            if_pc          <= 32'h0;
            if_pc_plus4    <= 32'h0;
        end else if (redir) begin
            pc       <= redir_target;
            if_valid <= 1'b0;
            if (state == S_WAIT) begin
                drop <= !imem_resp_valid;
            end
        end else begin
            if (load) begin
                if_instruction <= imem_resp_data;
                if_pc          <= pc;
                if_pc_plus4    <= pc + 32'd4;
                if_valid       <= 1'b1;
                pc             <= pc + 32'd4;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
            if (state == S_WAIT && imem_resp_valid) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a one-cycle memory model feeds the DUT while a
// scoreboard monitor checks every accepted request address and every presented instruction.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } out_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redir_jump;
    logic        redir_branch;
    logic [31:0] redir_pc4;
    logic [25:0] redir_adr;
    logic [15:0] redir_imm;

    int          checks = 0;
    int          errors = 0;
    int          resp_delay = 1;
    logic [31:0] exp_req[$];
    out_t        exp_out[$];
    logic [4:0]  pattern;

    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cnt = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instruction(if_instruction),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .redir_jump(redir_jump),
        .redir_branch(redir_branch),
        .redir_pc4(redir_pc4),
        .redir_adr(redir_adr),
        .redir_imm(redir_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h0109_5020;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with nothing expected", name);
    endtask

    task automatic push_out(input logic [31:0] a, input logic [31:0] a4);
        out_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        e.pc4   = a4;
        exp_out.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        tick();
        rst          = 1'b1;
        redir_jump   = 1'b0;
        redir_branch = 1'b0;
    endtask

    task automatic end_reset();
        tick();
        @(negedge clk);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_instruction", if_instruction, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    // Memory model: answers each accepted request resp_delay cycles later.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (pend && cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
                pend            = 1'b0;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'hBAD0_BAD0;
                if (pend) cnt--;
            end
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = resp_delay - 1;
            end
        end
    end

    // Monitor: a flushed instruction (redirect in its only visible cycle) is not checked.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                if (exp_req.size() == 0) unexpected("req_extra");
                else check("req_addr", imem_addr, exp_req.pop_front());
            end
            if (if_valid === 1'b1 && !(redir_jump || redir_branch)) begin
                if (exp_out.size() == 0) begin
                    unexpected("out_extra");
                end else begin
                    check("out_instruction", if_instruction, exp_out[0].instr);
                    check("out_pc", if_pc, exp_out[0].pc);
                    check("out_pc_plus4", if_pc_plus4, exp_out[0].pc4);
                    if (if_ready) void'(exp_out.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        redir_jump     = 1'b0;
        redir_branch   = 1'b0;
        redir_pc4      = 32'h0;
        redir_adr      = 26'h0;
        redir_imm      = 16'h0;

        // Straight-line fetch: valid every other cycle.
        start_reset();
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        resp_delay     = 1;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        push_out(32'h0, 32'h4);
        push_out(32'h4, 32'h8);
        end_reset();
        pattern = 5'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i == 4) imem_req_ready = 1'b0;
            @(negedge clk);
            pattern = {pattern[3:0], if_valid};
        end
        check("t1_valid_pattern", {27'h0, pattern}, 32'h5);

        // Decode back-pressure for 5 cycles.
        start_reset();
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        push_out(32'h0, 32'h4);
        push_out(32'h4, 32'h8);
        end_reset();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            check("t2_hold_valid", {31'h0, if_valid}, 32'h1);
            check("t2_hold_noreq", {31'h0, imem_req_valid}, 32'h0);
        end
        tick();
        if_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();

        // Jump while waiting with no response yet: the late response is dropped.
        start_reset();
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        resp_delay     = 2;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h0000_0100);
        push_out(32'h0000_0100, 32'h0000_0104);
        end_reset();
        tick();
        redir_jump = 1'b1;
        redir_pc4  = 32'h0040_0010;
        redir_adr  = 26'h000_0040;
        @(negedge clk);
        check("t3_noreq_in_wait", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redir_jump = 1'b0;
        resp_delay = 1;
        @(negedge clk);
        check("t3_no_valid_drop", {31'h0, if_valid}, 32'h0);
        tick();
        @(negedge clk);
        check("t3_dropped_not_loaded", {31'h0, if_valid}, 32'h0);
        check("t3_jump_addr", imem_addr, 32'h0000_0100);
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();

        // Branch target, jump+branch priority with flush, redirect with a live response.
        start_reset();
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        resp_delay     = 1;
        exp_req.push_back(32'h0000_0018);
        exp_req.push_back(32'h0000_000C);
        exp_req.push_back(32'h0000_0140);
        push_out(32'h0000_0140, 32'h0000_0144);
        end_reset();
        redir_branch = 1'b1;
        redir_pc4    = 32'h0000_0020;
        redir_imm    = 16'hFFFE;
        @(negedge clk);
        check("t4_noreq_on_redir", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redir_branch = 1'b0;
        tick();
        tick();
        redir_jump   = 1'b1;
        redir_branch = 1'b1;
        redir_adr    = 26'h000_0003;
        @(negedge clk);
        check("t4_valid_before_flush", {31'h0, if_valid}, 32'h1);
        check("t4_noreq_on_redir2", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redir_jump   = 1'b0;
        redir_branch = 1'b0;
        @(negedge clk);
        check("t4_flushed", {31'h0, if_valid}, 32'h0);
        tick();
        redir_branch = 1'b1;
        redir_pc4    = 32'h0000_0100;
        redir_imm    = 16'h0010;
        tick();
        redir_branch = 1'b0;
        @(negedge clk);
        check("t5_resp_discarded", {31'h0, if_valid}, 32'h0);
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();

        // PC wrap, then reset while waiting with the response arriving after reset.
        start_reset();
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        resp_delay     = 1;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0000);
        push_out(32'hFFFF_FFFC, 32'h0000_0000);
        push_out(32'h0000_0000, 32'h0000_0004);
        end_reset();
        redir_jump = 1'b1;
        redir_pc4  = 32'hF000_0000;
        redir_adr  = 26'h3FF_FFFF;
        tick();
        redir_jump     = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        resp_delay = 2;
        @(negedge clk);
        check("t6_wrap_pc_plus4", if_pc_plus4, 32'h0);
        check("t6_wrap_next_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_noreq_in_rst", {31'h0, imem_req_valid}, 32'h0);
        tick();
        rst        = 1'b0;
        resp_delay = 1;
        @(negedge clk);
        check("t6_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("t6_first_req_addr", imem_addr, 32'h0);
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("t6_stray_ignored", {31'h0, if_valid}, 32'h0);
        tick();
        tick();

        @(negedge clk);
        check("sb_req_drained", exp_req.size(), 32'h0);
        check("sb_out_drained", exp_out.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
